// File: rtl/loader_pkg.sv
// Shared types and default constants for the UART program loader and its receiver.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOADING,
        DONE
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int CLKS_PER_BIT_115200 = 868;
    localparam int TIMEOUT_DEFAULT     = 1_000_000;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit sampling,
// one-cycle byte_valid on a good stop bit or byte_err on a bad one.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             prev_q;
    logic             byte_valid_q;
    logic             byte_err_q;
    logic [7:0]       byte_data_q;

    // Only a high-to-low transition starts a frame, so a line held low after a
    // bad stop bit cannot retrigger the receiver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            prev_q       <= 1'b1;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
            byte_data_q  <= '0;
        end else begin
            prev_q       <= rx_sync;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !rx_sync) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= shift_q;
                        end else begin
                            byte_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_err   = byte_err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program image from the UART into instruction memory as big-endian
// 32-bit words, finishing on line timeout or when memory is full.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int ADDR_W       = 14,
    parameter int TIMEOUT_CLKS = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pg,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CLKS);
    localparam logic [ADDR_W:0]  LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    logic rx_meta_q;
    logic rx_sync_q;
    logic byte_valid;
    logic byte_err;
    logic [7:0] byte_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_sync    (rx_sync_q),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err)
    );

    load_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       word_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              frame_err_q;

    // word_q is zeroed after every write, so a timeout flush of a partial word
    // naturally carries 0x00 in its unfilled low bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            word_cnt_q   <= '0;
            tmo_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_pg) begin
                        state_q     <= ARMED;
                        addr_q      <= '0;
                        byte_idx_q  <= '0;
                        word_q      <= '0;
                        word_cnt_q  <= '0;
                        tmo_q       <= '0;
                        frame_err_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (!start_pg) begin
                        state_q <= IDLE;
                    end else begin
                        if (byte_err) begin
                            frame_err_q <= 1'b1;
                        end
                        if (byte_valid) begin
                            word_q     <= {byte_data, 24'h0};
                            byte_idx_q <= 2'd1;
                            tmo_q      <= '0;
                            state_q    <= LOADING;
                        end
                    end
                end
                LOADING: begin
                    if (!start_pg) begin
                        state_q <= IDLE;
                    end else begin
                        if (byte_err) begin
                            frame_err_q <= 1'b1;
                        end
                        if (byte_valid) begin
                            tmo_q <= '0;
                            if (byte_idx_q == 2'd3) begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= addr_q;
                                imem_wdata_q <= {word_q[31:8], byte_data};
                                addr_q       <= addr_q + 1'b1;
                                word_cnt_q   <= word_cnt_q + 1'b1;
                                byte_idx_q   <= '0;
                                word_q       <= '0;
                                if (word_cnt_q == LAST_CNT) begin
                                    state_q <= DONE;
                                end
                            end else begin
                                word_q[31 - 8*byte_idx_q -: 8] <= byte_data;
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end else if (tmo_q == TMO_MAX) begin
                            // Flush first; DONE follows once byte_idx is back to zero.
                            if (byte_idx_q != 2'd0) begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= addr_q;
                                imem_wdata_q <= word_q;
                                addr_q       <= addr_q + 1'b1;
                                word_cnt_q   <= word_cnt_q + 1'b1;
                                byte_idx_q   <= '0;
                                word_q       <= '0;
                            end else begin
                                state_q <= DONE;
                            end
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start_pg) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = (state_q == ARMED) || (state_q == LOADING);
    assign done       = (state_q == DONE);
    assign frame_err  = frame_err_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized UART load sequences checked against a byte-list model
// of the expected IMEM writes.
module tb_uart_prog_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 2;
    localparam int TMO    = 2000;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_pg;
    logic              rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [ADDR_W:0]   word_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int back_to_back = 0;
    logic prev_we = 1'b0;

    int          obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    logic [7:0]  good_q[$];

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_pg   (start_pg),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            obs_addr_q.push_back(int'(imem_addr));
            obs_data_q.push_back(imem_wdata);
            if (prev_we === 1'b1) back_to_back++;
        end
        prev_we = imem_we;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        good_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic arm();
        obs_addr_q.delete();
        obs_data_q.delete();
        good_q.delete();
        start_pg = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    // Expected writes come straight from the list of accepted bytes:
    // groups of four, big-endian, zero-padded, capped at memory depth.
    task automatic check_writes(input string tag);
        int n      = good_q.size();
        int nwords = (n + 3) / 4;
        logic [31:0] w;
        if (nwords > DEPTH) nwords = DEPTH;
        check({tag, "_nwrites"}, obs_addr_q.size(), nwords);
        check({tag, "_word_cnt"}, word_cnt, nwords);
        for (int k = 0; k < nwords && k < obs_addr_q.size(); k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) w = w | (32'(good_q[4 * k + j]) << (24 - 8 * j));
            end
            check($sformatf("%s_addr%0d", tag, k), obs_addr_q[k], k);
            check($sformatf("%s_data%0d", tag, k), obs_data_q[k], w);
        end
    endtask

    task automatic disarm(input string tag);
        start_pg = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_idle_done"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] seq8 [8];
        logic [7:0] b;
        int n;
        int bad_pos;

        rst = 1'b1;
        rx = 1'b1;
        start_pg = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_wcnt", word_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] two full words");
        seq8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        arm();
        check("t1_busy", busy, 1);
        foreach (seq8[i]) send_good(seq8[i]);
        wait_done("t1", TMO + 200);
        check_writes("t1");
        check("t1_ferr", frame_err, 0);
        disarm("t1");

        $display("[TB] partial word flush");
        arm();
        send_good(8'hAA);
        send_good(8'hBB);
        send_good(8'hCC);
        wait_done("t2", TMO + 200);
        check_writes("t2");
        disarm("t2");

        $display("[TB] bad stop bit");
        arm();
        send_good(8'h11);
        send_good(8'h22);
        send_frame(8'h33, 1'b0);
        check("t3_ferr_mid", frame_err, 1);
        send_good(8'h44);
        send_good(8'h55);
        wait_done("t3", TMO + 200);
        check_writes("t3");
        check("t3_ferr", frame_err, 1);
        disarm("t3");

        $display("[TB] start glitch");
        arm();
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t4_busy", busy, 1);
        check("t4_done", done, 0);
        check("t4_nwrites", obs_addr_q.size(), 0);
        check("t4_ferr", frame_err, 0);
        for (int i = 0; i < 4; i++) send_good(8'(8'hC0 + i));
        wait_done("t4", TMO + 200);
        check_writes("t4");
        disarm("t4");

        $display("[TB] memory full");
        arm();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(255, 0));
            send_good(b);
        end
        wait_done("t5", 20);
        check_writes("t5");
        disarm("t5");

        $display("[TB] reset mid-frame");
        arm();
        send_good(8'h5A);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(i & 1);
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("t6_we", imem_we, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_wcnt", word_cnt, 0);
        check("t6_addr", imem_addr, 0);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_pg = 1'b0;
        repeat (2) @(negedge clk);
        arm();
        foreach (seq8[i]) if (i < 4) send_good(seq8[i]);
        wait_done("t6", TMO + 200);
        check_writes("t6");
        disarm("t6");

        $display("[TB] abort");
        arm();
        send_good(8'h01);
        send_good(8'h02);
        start_pg = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        check("t7_nwrites", obs_addr_q.size(), 0);

        $display("[TB] randomized loads");
        for (int it = 0; it < 3; it++) begin
            arm();
            n = $urandom_range(11, 1);
            bad_pos = $urandom_range(n, 0);
            for (int i = 0; i < n; i++) begin
                if (it != 0 && i == bad_pos) send_frame(8'($urandom_range(255, 0)), 1'b0);
                send_good(8'($urandom_range(255, 0)));
            end
            wait_done($sformatf("r%0d", it), TMO + 200);
            check_writes($sformatf("r%0d", it));
            check($sformatf("r%0d_ferr", it), frame_err, (it != 0 && bad_pos < n) ? 1 : 0);
            disarm($sformatf("r%0d", it));
        end

        check("we_back_to_back", back_to_back, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
